// File: rtl/spi_tx_lanes.sv
// spi_tx_lanes: serialises FIFO words onto 1/2/4 SPI data lanes,
// paced by the clock generator's shift strobe.
module spi_tx_lanes #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              en_i,
    input  logic              tx_edge_i,
    input  logic [1:0]        mode_i,
    input  logic              lsb_first_i,
    input  logic [LEN_W-1:0]  tx_len_i,
    input  logic              tx_len_update_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_data_vld_i,
    output logic              tx_data_rdy_o,
    output logic [3:0]        sdo_o,
    output logic [3:0]        sdo_oe_o,
    output logic              tx_done_o,
    output logic              underrun_o,
    output logic              busy_o
);
    localparam int WC_W = $clog2(DATA_W) + 1;

    typedef enum logic {S_IDLE, S_TRANSMIT} state_t;

    state_t            r_state;
    logic [LEN_W-1:0]  r_target;
    logic [LEN_W-1:0]  r_bit_cnt;
    logic [WC_W-1:0]   r_word_cnt;
    logic [DATA_W-1:0] r_sr;
    logic [1:0]        r_mode;
    logic              r_lsb;

    logic              w_busy;
    logic              w_active;
    logic              w_last;
    logic              w_bound;
    logic              w_start;
    logic [2:0]        w_step;
    logic [LEN_W:0]    w_bit_sum;
    logic [WC_W-1:0]   w_word_sum;

    always_comb begin
        unique case (r_mode)
            2'd1:    w_step = 3'd2;
            2'd2:    w_step = 3'd4;
            default: w_step = 3'd1;
        endcase
    end

    // An abort (en_i low) masks every edge-driven event.
    assign w_busy     = (r_state == S_TRANSMIT);
    assign w_active   = w_busy & en_i & tx_edge_i;
    assign w_bit_sum  = {1'b0, r_bit_cnt} + (LEN_W+1)'(w_step);
    assign w_word_sum = r_word_cnt + WC_W'(w_step);
    assign w_last     = w_active & (w_bit_sum >= {1'b0, r_target});
    assign w_bound    = w_active & ~w_last
                      & (w_word_sum == WC_W'(DATA_W));

    assign tx_data_rdy_o = w_busy ? w_bound : (r_target != '0);
    assign w_start    = ~w_busy & en_i & tx_data_vld_i & tx_data_rdy_o;
    assign tx_done_o  = w_last;
    assign underrun_o = w_bound & ~tx_data_vld_i;
    assign busy_o     = w_busy;

    always_comb begin
        sdo_o    = '0;
        sdo_oe_o = '0;
        if (w_busy) begin
            unique case (r_mode)
                2'd1: begin
                    sdo_oe_o   = 4'b0011;
                    sdo_o[1:0] = r_lsb ? r_sr[1:0]
                                       : r_sr[DATA_W-1 -: 2];
                end
                2'd2: begin
                    sdo_oe_o = 4'b1111;
                    sdo_o    = r_lsb ? r_sr[3:0]
                                     : r_sr[DATA_W-1 -: 4];
                end
                default: begin
                    sdo_oe_o = 4'b0001;
                    sdo_o[0] = r_lsb ? r_sr[0] : r_sr[DATA_W-1];
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= S_IDLE;
            r_target   <= '0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_sr       <= '0;
            r_mode     <= '0;
            r_lsb      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (tx_len_update_i)
                        r_target <= tx_len_i;
                    if (w_start) begin
                        r_state    <= S_TRANSMIT;
                        r_sr       <= tx_data_i;
                        r_bit_cnt  <= '0;
                        r_word_cnt <= '0;
                        r_mode     <= mode_i;
                        r_lsb      <= lsb_first_i;
                    end
                end
                S_TRANSMIT: begin
                    if (!en_i || w_last || underrun_o) begin
                        r_state <= S_IDLE;
                    end else if (w_bound) begin
                        r_sr       <= tx_data_i;
                        r_word_cnt <= '0;
                        r_bit_cnt  <= w_bit_sum[LEN_W-1:0];
                    end else if (tx_edge_i) begin
                        r_sr       <= r_lsb ? (r_sr >> w_step)
                                            : (r_sr << w_step);
                        r_word_cnt <= w_word_sum;
                        r_bit_cnt  <= w_bit_sum[LEN_W-1:0];
                    end
                end
            endcase
        end
    end
endmodule
